multiword_adder_seq: RTL and testbench
======================================

MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
REQ-001 SHALL have parameter N, default 4: word width in bits of the combinational adder slice.
REQ-002 SHALL have parameter WORDS, default 4: number of N-bit words per operand; total width W = N*WORDS.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: request to begin an add when idle.
REQ-006 SHALL have port a_in, input, W: operand A, sampled only on an accepted start.
REQ-007 SHALL have port b_in, input, W: operand B, sampled only on an accepted start.
REQ-008 SHALL have port cin, input, 1: carry-in to word 0, sampled on an accepted start.
REQ-009 SHALL have port busy, output, 1: high while words are being processed.
REQ-010 SHALL have port done, output, 1: single-cycle pulse when the result is valid.
REQ-011 SHALL have port sum_out, output, W: registered result, held until the next accepted start.
REQ-012 SHALL have port cout_out, output, 1: registered carry-out of the most significant word.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it latches a_in, b_in and cin, clears the word index, and enters RUN.
REQ-015 SHALL ignore start while in RUN, leaving operands and progress unaffected.
REQ-016 SHALL in RUN add word k (bits k*N+N-1:k*N) of A and B plus the stored carry once per cycle, write the word into the sum register, store the slice carry-out for word k+1, and increment k.
REQ-017 SHALL, after word WORDS-1, load cout_out from the final carry and go to DONE; k wraps to 0 and never exceeds WORDS-1.
REQ-018 SHALL pulse done for exactly one cycle in DONE, then return to IDLE unless start is accepted that same cycle, in which case it enters RUN directly.
REQ-019 SHALL give a start-to-done latency of exactly WORDS+1 cycles: start sampled at edge 0, done high after edge WORDS+1.
REQ-020 SHALL drive busy high exactly when in RUN.
REQ-021 SHALL update sum_out and cout_out only at word writes and at reset, so that a result is stable from done until the first RUN write of the next operation.
REQ-022 SHALL produce sum_out and cout_out bit-exact to {cout,sum} = A + B + cin, taken modulo 2^(W+1).

Reset
REQ-023 SHALL, when rst_n is low at any time, immediately force IDLE, busy=0, done=0, sum_out=0, cout_out=0, and clear the index, carry and operand registers.
REQ-024 SHALL discard an operation aborted by reset mid-RUN, with no done pulse; the first start after rst_n rises is accepted normally.

Configuration
REQ-025 SHALL, with macro MWADD_SUB_EN defined, add port sub (input, 1, sampled on accepted start); sub=1 computes A + ~B + 1 with cin ignored, and cout_out=1 means no borrow.
REQ-026 SHALL, without MWADD_SUB_EN, have no sub port and always add.

Structure
REQ-027 SHALL place the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default N/WORDS constants in shared package mwadd_pkg.
REQ-028 SHALL instantiate exactly one combinational N-bit full_adder sub-module (ports a, b, cin, s, cout) as the per-cycle slice; carry rippling between words is done only through the stored carry register.

Verification (N=4, WORDS=4, W=16)
REQ-029 SHALL verify that a=16'hFFFF, b=16'h0001, cin=0, start -> busy for 4 cycles, done 5 cycles after start, sum_out=16'h0000, cout_out=1.
REQ-030 SHALL verify that a=16'h1234, b=16'h4321, cin=1 -> sum_out=16'h5556, cout_out=0, one done pulse.
REQ-031 SHALL verify that start with a=16'h0001, b=16'h0001, followed by a second start (a=16'hAAAA) two cycles later -> sum_out=16'h0002, and the second start is ignored.
REQ-032 SHALL verify that rst_n pulsed low 2 cycles into RUN -> busy, done, sum_out and cout_out all 0 at once, no done pulse, and a later start (16'h0003+16'h0004) gives 16'h0007.
REQ-033 SHALL verify that a start asserted in the done cycle -> RUN the next cycle (no IDLE cycle), with a second correct result WORDS+1 cycles later.
REQ-034 SHALL verify, with MWADD_SUB_EN, that a=16'h0005, b=16'h0007, sub=1 -> sum_out=16'hFFFE, cout_out=0; and a=16'h0007, b=16'h0005 -> 16'h0002, cout_out=1.

Source files
------------

// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the word-serial multiword adder: FSM encoding and default geometry.
package mwadd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int MWADD_N_DEF     = 4;
   localparam int MWADD_WORDS_DEF = 4;

endpackage : mwadd_pkg

// File: rtl/multiword_adder_seq_full_adder.sv
// Combinational N-bit adder slice; one instance is reused for every word of the operand.
module full_adder
#(
   parameter int N = 4
)(
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] total_s;

   // Zero-extend to N+1 bits so the top bit of the sum is the slice carry-out.
   assign total_s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign s       = total_s[N-1:0];
   assign cout    = total_s[N];

endmodule : full_adder

// File: rtl/multiword_adder_seq.sv
// Word-serial W = N*WORDS bit adder: one N-bit word per cycle, carry kept in a register.
// Optional macro MWADD_SUB_EN adds a 'sub' input that selects A - B (A + ~B + 1).
module multiword_adder_seq
   import mwadd_pkg::*;
#(
   parameter  int N     = MWADD_N_DEF,
   parameter  int WORDS = MWADD_WORDS_DEF,
   localparam int W     = N * WORDS
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum_out,
   output logic         cout_out
`ifdef MWADD_SUB_EN
   ,
   input  logic         sub
`endif
);

   localparam int            KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [W-1:0]  b_lat_s;
   logic          cin_lat_s;
   logic [N-1:0]  slice_a_s;
   logic [N-1:0]  slice_b_s;
   logic [N-1:0]  slice_s_s;
   logic          slice_c_s;

   // Operand B and carry-in as they are captured on an accepted start.
   always_comb begin
      b_lat_s   = b_in;
      cin_lat_s = cin;
`ifdef MWADD_SUB_EN
      // Subtraction is two's-complement: invert B and force the carry-in high.
      if (sub) begin
         b_lat_s   = ~b_in;
         cin_lat_s = 1'b1;
      end else begin
         b_lat_s   = b_in;
         cin_lat_s = cin;
      end
`endif
   end

   assign slice_a_s = a_q[k_q*N +: N];
   assign slice_b_s = b_q[k_q*N +: N];

   full_adder #(
      .N (N)
   ) u_slice (
      .a    (slice_a_s),
      .b    (slice_b_s),
      .cin  (carry_q),
      .s    (slice_s_s),
      .cout (slice_c_s)
   );

   // Next-state, word sequencing and result accumulation.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_lat_s;
               carry_d = cin_lat_s;
               k_d     = {KW{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[k_q*N +: N] = slice_s_s;
            carry_d           = slice_c_s;
            if (k_q == K_LAST) begin
               k_d     = {KW{1'b0}};
               cout_d  = slice_c_s;
               state_d = DONE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = RUN;
            end
         end
         DONE: begin
            // done is registered, so it appears the cycle after DONE is entered.
            done_d = 1'b1;
            if (start) begin
               a_d     = a_in;
               b_d     = b_lat_s;
               carry_d = cin_lat_s;
               k_d     = {KW{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = {KW{1'b0}};
         end
      endcase

      busy_d = (state_d == RUN);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= {KW{1'b0}};
         carry_q <= 1'b0;
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         sum_q   <= {W{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum_out  = sum_q;
   assign cout_out = cout_q;

endmodule : multiword_adder_seq

// File: tb/tb_multiword_adder_seq.sv
// Directed bench for multiword_adder_seq (N=4, WORDS=4); covers MWADD_SUB_EN when defined.
module tb_multiword_adder_seq;

   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout_out;
`ifdef MWADD_SUB_EN
   logic         sub;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t vecs[8];

   multiword_adder_seq #(
      .N     (N),
      .WORDS (WORDS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
`ifdef MWADD_SUB_EN
      ,
      .sub      (sub)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Start an add, scramble the inputs, then check busy/done timing and the result.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [15:0] es, input logic ec, input string nm);
      @(negedge clk);
      a_in = a; b_in = b; cin = c; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
      for (int j = 0; j <= 6; j++) begin
         @(negedge clk);
         check({nm, " busy"}, {31'd0, busy}, {31'd0, (j < 4)});
         check({nm, " done"}, {31'd0, done}, {31'd0, (j == 5)});
         if (j == 5) begin
            check({nm, " sum"},  {16'd0, sum_out},  {16'd0, es});
            check({nm, " cout"}, {31'd0, cout_out}, {31'd0, ec});
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen_done;

      vecs[0] = '{a: 16'hFFFF, b: 16'h0001, c: 1'b0, s: 16'h0000, co: 1'b1};
      vecs[1] = '{a: 16'h1234, b: 16'h4321, c: 1'b1, s: 16'h5556, co: 1'b0};
      vecs[2] = '{a: 16'h0000, b: 16'h0000, c: 1'b0, s: 16'h0000, co: 1'b0};
      vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, c: 1'b1, s: 16'hFFFF, co: 1'b1};
      vecs[4] = '{a: 16'h8000, b: 16'h8000, c: 1'b0, s: 16'h0000, co: 1'b1};
      vecs[5] = '{a: 16'h0FFF, b: 16'h0001, c: 1'b0, s: 16'h1000, co: 1'b0};
      vecs[6] = '{a: 16'hABCD, b: 16'h1111, c: 1'b0, s: 16'hBCDE, co: 1'b0};
      vecs[7] = '{a: 16'h7FFF, b: 16'h0000, c: 1'b1, s: 16'h8000, co: 1'b0};

      rst_n = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
`ifdef MWADD_SUB_EN
      sub = 1'b0;
`endif
      #2 rst_n = 1'b0;
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset sum",  {16'd0, sum_out}, 32'd0);
      check("reset cout", {31'd0, cout_out}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));
      end

      // Second start two cycles into RUN must be ignored.
      @(negedge clk);
      a_in = 16'h0001; b_in = 16'h0001; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int j = 2; j <= 8; j++) begin
         @(negedge clk);
         check("ignore busy", {31'd0, busy}, {31'd0, (j < 4)});
         check("ignore done", {31'd0, done}, {31'd0, (j == 5)});
         if (j == 5) begin
            check("ignore sum",  {16'd0, sum_out},  32'h0002);
            check("ignore cout", {31'd0, cout_out}, 32'd0);
         end
      end

      // Reset asserted mid-RUN clears everything at once and no done follows.
      @(negedge clk);
      a_in = 16'h1234; b_in = 16'h1111; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrun busy", {31'd0, busy}, 32'd1);
      check("midrun sum",  {16'd0, sum_out}, 32'h0045);
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort sum",  {16'd0, sum_out}, 32'd0);
      check("abort cout", {31'd0, cout_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort no done", {31'd0, seen_done}, 32'd0);
      run_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "after reset");

      // Start accepted in the DONE cycle goes straight back to RUN.
      @(negedge clk);
      a_in = 16'h0010; b_in = 16'h0020; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      a_in = 16'h0100; b_in = 16'h0200; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("b2b done1", {31'd0, done}, 32'd1);
      check("b2b busy",  {31'd0, busy}, 32'd1);
      check("b2b sum1",  {16'd0, sum_out}, 32'h0030);
      for (int j = 6; j <= 11; j++) begin
         @(negedge clk);
         check("b2b busy2", {31'd0, busy}, {31'd0, (j <= 8)});
         check("b2b done2", {31'd0, done}, {31'd0, (j == 10)});
         if (j == 10) begin
            check("b2b sum2",  {16'd0, sum_out},  32'h0301);
            check("b2b cout2", {31'd0, cout_out}, 32'd0);
         end
      end

`ifdef MWADD_SUB_EN
      sub = 1'b1;
      run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, "sub 5-7");
      run_op(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, "sub 7-5");
      run_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, "sub cin ignored");
      sub = 1'b0;
      run_op(16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, "add after sub");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_multiword_adder_seq
